mac_tx_fcs_ctrl: RTL and testbench
==================================

# mac_tx_fcs_ctrl

Transmit-side MAC framer. It accepts an Ethernet frame as a byte stream (DA through payload) from the UDP/IP packer and emits it on a GMII-style 8-bit interface. On the way it prepends preamble/SFD, optionally pads the frame to minimum length, appends the 4-byte FCS and enforces the inter-frame gap. It sequences one `crc32_check` engine instance through `CRC32_init` and `CRC32_en`, and serialises that engine's result into the FCS bytes.

## Interface
Parameters:
- `PREAMBLE_LEN`, default 7: number of 0x55 bytes sent before the SFD byte 0xD5.
- `MIN_FRAME`, default 60: minimum DA..payload length in bytes, excluding FCS. Used only when `MAC_TX_PAD_EN` is defined.
- `IFG_BYTES`, default 12: idle cycles between frames.

Ports:
- `clk` in 1: byte clock (125 MHz for GMII).
- `reset` in 1: asynchronous, active-high; clock `clk`.
- `s_data` in 8: frame byte from upstream.
- `s_valid` in 1: `s_data` valid.
- `s_last` in 1: marks the final DA..payload byte.
- `s_ready` out 1: block accepts a byte on this cycle.
- `txd` out 8: GMII transmit data, registered.
- `tx_en` out 1: GMII transmit enable, registered.
- `tx_er` out 1: GMII transmit error, registered.
- `frame_done` out 1: one-cycle pulse when the IFG of a frame completes.
- `underrun` out 1: one-cycle pulse when a mid-frame `s_valid` drop is detected.

## Operation
States: IDLE, PRE, DATA, PAD, FCS, DRAIN, IFG.
- **IDLE**
  - `s_ready`=0.
  - `s_valid`=1 → PRE. The preamble counter clears.
- **PRE**
  - Emits `PREAMBLE_LEN`×0x55, then 0xD5 (`PREAMBLE_LEN`+1 cycles total).
  - `CRC32_init`=1 for every PRE cycle.
  - After the 0xD5 cycle → DATA.
- **DATA**
  - `s_ready`=1.
  - On each accept (`s_valid`&`s_ready`): `CRC32_en`=1 with the engine's data input = `s_data`, and the output register loads `s_data`. The 16-bit `byte_cnt` increments and saturates at 0xFFFF.
  - Accept with `s_last`=1: → PAD if `MAC_TX_PAD_EN` is defined and `byte_cnt`+1 < `MIN_FRAME`; otherwise → FCS.
  - `s_valid`=0 in DATA is an underrun: pulse `underrun`, → DRAIN.
- **PAD**
  - Each cycle: emit 0x00, `CRC32_en`=1 with data 0x00, increment `byte_cnt`.
  - When `byte_cnt` reaches `MIN_FRAME` → FCS.
- **FCS**
  - 4 cycles. The 2-bit index k runs 0..3.
  - `CRC32_en`=0, so the CRC is frozen.
  - Byte k = ~{`CRC_data`[24-8k], `CRC_data`[25-8k], …, `CRC_data`[31-8k]}. `CRC_data`[24-8k] goes to `txd`[7]; equivalently, the top byte is emitted first, bit-reversed and inverted.
  - After k=3 → IFG.
- **DRAIN**
  - `s_ready`=1; accepted bytes are discarded.
  - `tx_en`=1, `tx_er`=1, `txd`=0x00.
  - When `s_last` is accepted → IFG. No FCS is sent.
- **IFG**
  - `tx_en`=0, `tx_er`=0 for `IFG_BYTES` cycles.
  - On the last IFG cycle, pulse `frame_done` and → IDLE.
  - `s_ready`=0 in IFG.
- Only DATA and DRAIN assert `s_ready`. Upstream must present a frame contiguously once its first byte is accepted.

## Timing
- Reset values: `txd`=0x00, `tx_en`=0, `tx_er`=0, `s_ready`=0, `frame_done`=0, `underrun`=0; state IDLE; all counters 0. The CRC engine shares `reset`.
- Outputs are registered. A byte that is accepted, or generated, in cycle t appears on `txd` in cycle t+1.
- First preamble byte appears 2 cycles after `s_valid` is first seen high in IDLE.
- If the last DATA/PAD byte is accepted in cycle t, FCS byte 0 appears in t+2, so output is contiguous. `tx_en` stays high from the first 0x55 through FCS byte 3 with no gaps.
- Minimum frame-to-frame spacing on `txd` is `IFG_BYTES` cycles of `tx_en`=0.
- `s_last` together with an underrun is impossible: `s_last` is only sampled with `s_valid`=1.
- Reset mid-frame: outputs drop to reset values asynchronously. Upstream must restart the frame.

## Configuration
- `MAC_TX_PAD_EN` defined: frames shorter than `MIN_FRAME` are zero-padded, and the padding is covered by the FCS.
- `MAC_TX_PAD_EN` undefined: PAD state and comparator are absent; DATA goes straight to FCS on `s_last`. `byte_cnt` is still kept for saturation checks.

## Structure
- Package `mac_tx_pkg`:
  - state enum;
  - constants `PREAMBLE_BYTE`=8'h55, `SFD_BYTE`=8'hD5, `PAD_BYTE`=8'h00;
  - CRC residue constant 32'hC704DD7B, used by the bench.
- One sub-module: an instance of the existing `crc32_check` engine. Its `CRC32_init`/`CRC32_en`/`data` inputs are driven from a combinational mux of `s_data` / `PAD_BYTE`.

## Test plan
- **Standard check value:** pad disabled, 9-byte payload "123456789" (0x31..0x39) → `txd` carries 7×0x55, 0xD5, the 9 bytes, then FCS 0x26, 0x39, 0xF4, 0xCB; `tx_en` is high for 21 cycles; IFG follows.
- **Padding:** pad enabled, 14-byte frame → 46 pad bytes of 0x00 follow it, then FCS. Total `tx_en` high = 8+60+4 = 72 cycles. A second CRC engine fed with the post-SFD `txd` bytes reads 32'hC704DD7B after FCS byte 3.
- **Back-to-back:** two 64-byte frames with `s_valid` held high → exactly 12 cycles of `tx_en`=0 between FCS byte 3 and the next 0x55; one `frame_done` per frame.
- **Underrun:** `s_valid` dropped for 1 cycle after byte 20 of 64 → `underrun` pulses once, `tx_en`=`tx_er`=1 until `s_last` is accepted, no FCS is emitted, then the 12-cycle IFG.
- **Async reset:** `reset` asserted during FCS byte 1 → `tx_en`=0 and `txd`=0 immediately. The next frame's CRC is correct (check-value test repeats cleanly).
- **Saturation:** 70000-byte frame → `byte_cnt` holds at 0xFFFF, FCS is still correct (residue check passes), no spurious PAD state.

Source files
------------

// File: rtl/mac_tx_pkg.sv
// Shared types and constants for the transmit MAC framer and its CRC engine.
package mac_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE,
        ST_DATA,
        ST_PAD,
        ST_FCS,
        ST_DRAIN,
        ST_IFG
    } mac_tx_state_t;

    localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE      = 8'hD5;
    localparam logic [7:0]  PAD_BYTE      = 8'h00;

    localparam logic [31:0] CRC_POLY      = 32'h04C11DB7;
    localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;
    localparam logic [31:0] CRC_RESIDUE   = 32'hC704DD7B;

    // FCS byte k: top byte of the shifted CRC, bit-reversed and inverted.
    function automatic logic [7:0] fcs_byte(input logic [31:0] crc, input logic [1:0] k);
        logic [31:0] sh;
        logic [7:0]  b;
        sh = crc << {k, 3'b000};
        for (int i = 0; i < 8; i++) begin
            b[i] = ~sh[31-i];
        end
        return b;
    endfunction

endpackage

// File: rtl/crc32_check.sv
// Byte-wide CRC-32 engine (poly 0x04C11DB7, MSB-first register, data bits LSB first).
module crc32_check
    import mac_tx_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        CRC32_init,
    input  logic        CRC32_en,
    input  logic [7:0]  data,
    output logic [31:0] CRC_data
);

    logic [31:0] crc_reg;
    logic [31:0] crc_next;

    always_comb begin
        crc_next = crc_reg;
        for (int i = 0; i < 8; i++) begin
            crc_next = {crc_next[30:0], 1'b0} ^ ({32{crc_next[31] ^ data[i]}} & CRC_POLY);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            crc_reg <= CRC_INIT;
        end else if (CRC32_init) begin
            crc_reg <= CRC_INIT;
        end else if (CRC32_en) begin
            crc_reg <= crc_next;
        end
    end

    assign CRC_data = crc_reg;

endmodule

// File: rtl/mac_tx_fcs_ctrl.sv
// GMII transmit framer: preamble/SFD, optional minimum-length padding (MAC_TX_PAD_EN),
// FCS append and inter-frame gap.
module mac_tx_fcs_ctrl
    import mac_tx_pkg::*;
#(
    parameter int PREAMBLE_LEN = 7,
    parameter int MIN_FRAME    = 60,
    parameter int IFG_BYTES    = 12
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] s_data,
    input  logic       s_valid,
    input  logic       s_last,
    output logic       s_ready,
    output logic [7:0] txd,
    output logic       tx_en,
    output logic       tx_er,
    output logic       frame_done,
    output logic       underrun
);

    // The IDLE cycle that precedes the next preamble also carries tx_en=0,
    // so the IFG state itself lasts one cycle less than the visible gap.
    localparam logic [7:0] PRE_LAST = 8'(PREAMBLE_LEN);
    localparam logic [7:0] IFG_LAST = 8'((IFG_BYTES > 1) ? (IFG_BYTES - 2) : 0);

    mac_tx_state_t state_reg;
    logic [7:0]    pre_cnt_reg;
    logic [7:0]    ifg_cnt_reg;
    logic [1:0]    fcs_idx_reg;
    logic [15:0]   byte_cnt_reg;
    logic [7:0]    txd_reg;
    logic          tx_en_reg;
    logic          tx_er_reg;
    logic          s_ready_reg;
    logic          frame_done_reg;
    logic          underrun_reg;

    logic          crc_init;
    logic          crc_en;
    logic [7:0]    crc_din;
    logic [31:0]   crc_data;
    logic [15:0]   byte_cnt_next;

    assign crc_init      = (state_reg == ST_PRE);
    assign crc_en        = ((state_reg == ST_DATA) && s_valid) || (state_reg == ST_PAD);
    assign crc_din       = (state_reg == ST_PAD) ? PAD_BYTE : s_data;
    assign byte_cnt_next = (byte_cnt_reg == 16'hFFFF) ? byte_cnt_reg : byte_cnt_reg + 16'd1;

`ifdef MAC_TX_PAD_EN
    logic pad_needed;
    logic pad_full;
    assign pad_needed = ({1'b0, byte_cnt_reg} + 17'd1) < 17'(MIN_FRAME);
    assign pad_full   = (byte_cnt_next == 16'(MIN_FRAME));
`else
    // MIN_FRAME only matters when padding is built in.
    logic unused_min_frame;
    assign unused_min_frame = (MIN_FRAME > 0);
`endif

    crc32_check u_crc (
        .clk       (clk),
        .reset     (reset),
        .CRC32_init(crc_init),
        .CRC32_en  (crc_en),
        .data      (crc_din),
        .CRC_data  (crc_data)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg      <= ST_IDLE;
            pre_cnt_reg    <= '0;
            ifg_cnt_reg    <= '0;
            fcs_idx_reg    <= '0;
            byte_cnt_reg   <= '0;
            txd_reg        <= '0;
            tx_en_reg      <= 1'b0;
            tx_er_reg      <= 1'b0;
            s_ready_reg    <= 1'b0;
            frame_done_reg <= 1'b0;
            underrun_reg   <= 1'b0;
        end else begin
            frame_done_reg <= 1'b0;
            underrun_reg   <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    txd_reg     <= '0;
                    tx_en_reg   <= 1'b0;
                    tx_er_reg   <= 1'b0;
                    s_ready_reg <= 1'b0;
                    if (s_valid) begin
                        state_reg    <= ST_PRE;
                        pre_cnt_reg  <= '0;
                        byte_cnt_reg <= '0;
                    end
                end
                ST_PRE: begin
                    tx_en_reg <= 1'b1;
                    tx_er_reg <= 1'b0;
                    if (pre_cnt_reg == PRE_LAST) begin
                        txd_reg     <= SFD_BYTE;
                        s_ready_reg <= 1'b1;
                        state_reg   <= ST_DATA;
                    end else begin
                        txd_reg     <= PREAMBLE_BYTE;
                        pre_cnt_reg <= pre_cnt_reg + 8'd1;
                    end
                end
                ST_DATA: begin
                    tx_en_reg <= 1'b1;
                    if (s_valid) begin
                        txd_reg      <= s_data;
                        byte_cnt_reg <= byte_cnt_next;
                        if (s_last) begin
                            s_ready_reg <= 1'b0;
                            fcs_idx_reg <= '0;
`ifdef MAC_TX_PAD_EN
                            state_reg   <= pad_needed ? ST_PAD : ST_FCS;
`else
                            state_reg   <= ST_FCS;
`endif
                        end
                    end else begin
                        // Mid-frame gap: poison the frame and swallow the rest.
                        underrun_reg <= 1'b1;
                        txd_reg      <= '0;
                        tx_er_reg    <= 1'b1;
                        state_reg    <= ST_DRAIN;
                    end
                end
`ifdef MAC_TX_PAD_EN
                ST_PAD: begin
                    txd_reg      <= PAD_BYTE;
                    tx_en_reg    <= 1'b1;
                    byte_cnt_reg <= byte_cnt_next;
                    if (pad_full) begin
                        fcs_idx_reg <= '0;
                        state_reg   <= ST_FCS;
                    end
                end
`endif
                ST_FCS: begin
                    txd_reg     <= fcs_byte(crc_data, fcs_idx_reg);
                    tx_en_reg   <= 1'b1;
                    fcs_idx_reg <= fcs_idx_reg + 2'd1;
                    if (fcs_idx_reg == 2'd3) begin
                        ifg_cnt_reg <= '0;
                        state_reg   <= ST_IFG;
                    end
                end
                ST_DRAIN: begin
                    txd_reg   <= '0;
                    tx_en_reg <= 1'b1;
                    tx_er_reg <= 1'b1;
                    if (s_valid && s_last) begin
                        s_ready_reg <= 1'b0;
                        ifg_cnt_reg <= '0;
                        state_reg   <= ST_IFG;
                    end
                end
                ST_IFG: begin
                    txd_reg   <= '0;
                    tx_en_reg <= 1'b0;
                    tx_er_reg <= 1'b0;
                    if (ifg_cnt_reg == IFG_LAST) begin
                        frame_done_reg <= 1'b1;
                        state_reg      <= ST_IDLE;
                    end else begin
                        ifg_cnt_reg <= ifg_cnt_reg + 8'd1;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign s_ready    = s_ready_reg;
    assign txd        = txd_reg;
    assign tx_en      = tx_en_reg;
    assign tx_er      = tx_er_reg;
    assign frame_done = frame_done_reg;
    assign underrun   = underrun_reg;

endmodule

// File: tb/tb_mac_tx_fcs_ctrl.sv
// Directed bench for mac_tx_fcs_ctrl: captures each tx_en burst and compares it to a
// reflected-CRC reference frame plus hand-computed values.
module tb_mac_tx_fcs_ctrl;
    import mac_tx_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] s_data;
    logic       s_valid;
    logic       s_last;
    logic       s_ready;
    logic [7:0] txd;
    logic       tx_en;
    logic       tx_er;
    logic       frame_done;
    logic       underrun;

    mac_tx_fcs_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .s_data    (s_data),
        .s_valid   (s_valid),
        .s_last    (s_last),
        .s_ready   (s_ready),
        .txd       (txd),
        .tx_en     (tx_en),
        .tx_er     (tx_er),
        .frame_done(frame_done),
        .underrun  (underrun)
    );

    always #4 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int start_cyc   = 0;

    logic [7:0] cap[$];
    int         fstart[$];
    int         flen[$];
    int         ferr[$];
    int         fgap[$];
    int         frise[$];
    int         idle_run = 1000;
    bit         in_frame = 1'b0;
    int         n_done   = 0;
    int         n_under  = 0;
    logic [7:0] exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (tx_en) begin
            if (!in_frame) begin
                in_frame = 1'b1;
                fstart.push_back(cap.size());
                flen.push_back(0);
                ferr.push_back(0);
                fgap.push_back(idle_run);
                frise.push_back(cyc);
            end
            cap.push_back(txd);
            flen[flen.size()-1] = flen[flen.size()-1] + 1;
            if (tx_er) ferr[ferr.size()-1] = ferr[ferr.size()-1] + 1;
            idle_run = 0;
        end else begin
            in_frame = 1'b0;
            idle_run = idle_run + 1;
        end
        if (frame_done) n_done = n_done + 1;
        if (underrun) n_under = n_under + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] pay(input int seed, input int i);
        return 8'((seed + i) & 255);
    endfunction

    function automatic logic [31:0] crc_step(input logic [31:0] r, input logic [7:0] b);
        logic [31:0] c;
        c = r ^ {24'h0, b};
        for (int j = 0; j < 8; j++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        return c;
    endfunction

    task automatic build_exp(input int len, input int seed);
        logic [31:0] r;
        logic [7:0]  b;
        int          body;
        r = '1;
        exp_q.delete();
        for (int i = 0; i < 7; i++) exp_q.push_back(8'h55);
        exp_q.push_back(8'hD5);
        body = len;
`ifdef MAC_TX_PAD_EN
        if (body < 60) body = 60;
`endif
        for (int i = 0; i < body; i++) begin
            b = (i < len) ? pay(seed, i) : 8'h00;
            exp_q.push_back(b);
            r = crc_step(r, b);
        end
        r = ~r;
        exp_q.push_back(r[7:0]);
        exp_q.push_back(r[15:8]);
        exp_q.push_back(r[23:16]);
        exp_q.push_back(r[31:24]);
    endtask

    task automatic check_frame(input string tag, input int fi);
        int          bad;
        int          base;
        logic [31:0] r;
        logic [31:0] rev;
        if (fi >= fstart.size()) begin
            check({tag, "_present"}, fstart.size(), fi + 1);
            return;
        end
        base = fstart[fi];
        bad  = -1;
        check({tag, "_len"}, flen[fi], exp_q.size());
        check({tag, "_err"}, ferr[fi], 0);
        for (int i = 0; i < exp_q.size() && i < flen[fi]; i++) begin
            if (bad < 0 && cap[base+i] !== exp_q[i]) bad = i;
        end
        if (bad >= 0) check({tag, "_byte"}, cap[base+bad], exp_q[bad]);
        else check({tag, "_byte"}, cap[base+flen[fi]-1], exp_q[exp_q.size()-1]);
        r = '1;
        for (int i = 8; i < flen[fi]; i++) r = crc_step(r, cap[base+i]);
        for (int i = 0; i < 32; i++) rev[i] = r[31-i];
        check({tag, "_residue"}, rev, CRC_RESIDUE);
    endtask

    task automatic send_frame(input int len, input int seed, input int drop_at);
        int i;
        int guard;
        bit dropped;
        bit first;
        i = 0; guard = 0; dropped = 1'b0; first = 1'b1;
        while (i < len) begin
            @(negedge clk);
            if (first) begin
                start_cyc = cyc;
                first = 1'b0;
            end
            if (!dropped && drop_at > 0 && i == drop_at && s_ready) begin
                s_valid = 1'b0;
                s_last  = 1'b0;
                dropped = 1'b1;
            end else begin
                s_valid = 1'b1;
                s_data  = pay(seed, i);
                s_last  = (i == len - 1);
                if (s_ready) i++;
            end
            guard++;
            if (guard > len + 200) begin
                check("send_timeout", i, len);
                return;
            end
        end
    endtask

    task automatic go_idle();
        @(negedge clk);
        s_valid = 1'b0;
        s_last  = 1'b0;
        s_data  = 8'h00;
    endtask

    task automatic wait_done(input int target, input string tag);
        int g;
        g = 0;
        while (n_done < target && g < 500) begin
            @(negedge clk);
            g++;
        end
        repeat (2) @(negedge clk);
        check({tag, "_done"}, n_done, target);
    endtask

    initial begin
        #1_000_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int fi;
        int d0;
        int u0;
        int base;
        int tgt;
        int g;

        reset = 1'b1; s_valid = 1'b0; s_last = 1'b0; s_data = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_txd", txd, 0);
        check("rst_tx_en", tx_en, 0);
        check("rst_tx_er", tx_er, 0);
        check("rst_s_ready", s_ready, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_underrun", underrun, 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Check value "123456789".
        fi = fstart.size(); d0 = n_done;
        send_frame(9, 'h31, 0);
        go_idle();
        wait_done(d0 + 1, "chk");
        build_exp(9, 'h31);
        check_frame("chk", fi);
        if (fi < frise.size()) check("chk_latency", frise[fi] - start_cyc, 2);
`ifndef MAC_TX_PAD_EN
        if (fi < fstart.size()) begin
            base = fstart[fi];
            check("chk_fcs", {cap[base+17], cap[base+18], cap[base+19], cap[base+20]}, 32'h2639F4CB);
            check("chk_tx_en_cycles", flen[fi], 21);
        end
`endif

        // Short 14-byte frame (padded to 60 when padding is built in).
        fi = fstart.size(); d0 = n_done;
        send_frame(14, 'hA0, 0);
        go_idle();
        wait_done(d0 + 1, "short");
        build_exp(14, 'hA0);
        check_frame("short", fi);

        // Back-to-back 64-byte frames.
        fi = fstart.size(); d0 = n_done;
        send_frame(64, 'h07, 0);
        send_frame(64, 'h80, 0);
        go_idle();
        wait_done(d0 + 2, "b2b");
        build_exp(64, 'h07);
        check_frame("b2b_a", fi);
        build_exp(64, 'h80);
        check_frame("b2b_b", fi + 1);
        check("b2b_frames", fstart.size() - fi, 2);
        if (fstart.size() > fi + 1) check("b2b_gap", fgap[fi+1], 12);

        // Underrun after byte 20 of 64.
        fi = fstart.size(); d0 = n_done; u0 = n_under;
        send_frame(64, 'h11, 20);
        go_idle();
        wait_done(d0 + 1, "und");
        check("und_pulse", n_under - u0, 1);
        if (fi < fstart.size()) begin
            base = fstart[fi];
            check("und_len", flen[fi], 73);
            check("und_err_cycles", ferr[fi], 45);
            check("und_byte19", cap[base+27], pay('h11, 19));
            check("und_last_txd", cap[base+72], 0);
        end else begin
            check("und_present", fstart.size(), fi + 1);
        end

        // Asynchronous reset while FCS byte 1 is on txd.
        fi = fstart.size(); d0 = n_done;
        build_exp(9, 'h31);
        tgt = exp_q.size() - 2;
        send_frame(9, 'h31, 0);
        go_idle();
        g = 0;
        while ((fstart.size() <= fi || flen[fi] < tgt) && g < 100) begin
            @(negedge clk);
            #1;
            g++;
        end
        check("rst_mid_reached", (fstart.size() > fi) ? flen[fi] : 0, tgt);
        reset = 1'b1;
        #1;
        check("rst_mid_tx_en", tx_en, 0);
        check("rst_mid_txd", txd, 0);
        check("rst_mid_tx_er", tx_er, 0);
        if (fi < fstart.size()) check("rst_mid_fcs1", cap[fstart[fi]+tgt-1], exp_q[tgt-1]);
        @(negedge clk);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        check("rst_mid_no_done", n_done, d0);

        fi = fstart.size(); d0 = n_done;
        send_frame(9, 'h31, 0);
        go_idle();
        wait_done(d0 + 1, "rerun");
        build_exp(9, 'h31);
        check_frame("rerun", fi);

        // 70000-byte frame: byte counter saturates, FCS still correct.
        fi = fstart.size(); d0 = n_done;
        send_frame(70000, 'h5A, 0);
        go_idle();
        check("sat_byte_cnt", dut.byte_cnt_reg, 16'hFFFF);
        wait_done(d0 + 1, "sat");
        build_exp(70000, 'h5A);
        check_frame("sat", fi);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
